// File: rtl/conv_pkg.sv
// ============================================================================
//  conv_pkg
//  Shared types and sizing/saturation helpers for the expand-layer MAC engine.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int taps_f(input int kernel_dim, input int chin);
        return kernel_dim * kernel_dim * chin;
    endfunction

    // Product magnitude is at most 2^(2W-2); TAPS of them fit in 2W+clog2(TAPS) bits.
    function automatic int acc_width_f(input int width, input int taps);
        return 2 * width + $clog2(taps);
    endfunction

    function automatic int cnt_width_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [127:0] saturate_f(input logic signed [127:0] v,
                                                       input int width);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (width - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (width - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_mac_lane.sv
// ============================================================================
//  conv_mac_lane
//  One output channel: multiply, load/accumulate, bias, optional ReLU, rescale.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 8,
    parameter int TAPS    = 576,
    parameter int RELU_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] pix_i,
    input  logic signed [WIDTH-1:0] w_i,
    input  logic signed [WIDTH-1:0] bias_i,
    input  logic                    mac_en_i,
    input  logic                    first_i,
    input  logic                    last_i,
    output logic        [WIDTH-1:0] ofm_o
);

    localparam int ACC_W = acc_width_f(WIDTH, TAPS);
    localparam int SUM_W = ACC_W + 1;

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [SUM_W-1:0]   bias_ext, sum, sum_relu, res_sh;
    logic        [WIDTH-1:0]   ofm_q, ofm_d;

    // Post-processing works on acc_d so the result registers together with the last tap.
    always_comb begin
        prod  = pix_i * w_i;
        acc_d = acc_q;
        if (mac_en_i) begin
            acc_d = first_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
        end
        bias_ext = SUM_W'(bias_i) <<< FRAC;
        sum      = SUM_W'(acc_d) + bias_ext;
        sum_relu = ((RELU_EN != 0) && sum[SUM_W-1]) ? '0 : sum;
        res_sh   = sum_relu >>> FRAC;
        ofm_d    = ofm_q;
        if (mac_en_i && last_i) begin
            ofm_d = WIDTH'(saturate_f(128'(res_sh), WIDTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ofm_q <= '0;
        end else begin
            acc_q <= acc_d;
            ofm_q <= ofm_d;
        end
    end

    assign ofm_o = ofm_q;

endmodule

`default_nettype wire

// File: rtl/conv_expand_engine.sv
// ============================================================================
//  conv_expand_engine
//  Broadcasts one pixel stream to DSP_NO MAC lanes; owns control and counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module conv_expand_engine
    import conv_pkg::*;
#(
    parameter int DSP_NO     = 64,
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int CHIN       = 64,
    parameter int KERNEL_DIM = 3,
    parameter int OFM_PIXELS = 256,
    parameter int RELU_EN    = 1
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    output logic                                           busy,
    output logic                                           done,
    input  logic                                           ifm_valid,
    output logic                                           ifm_ready,
    input  logic signed [WIDTH-1:0]                        ifm,
    output logic [cnt_width_f(taps_f(KERNEL_DIM, CHIN))-1:0] w_addr,
    input  logic [DSP_NO*WIDTH-1:0]                        w_data,
    input  logic [DSP_NO*WIDTH-1:0]                        bias,
    output logic                                           ofm_valid,
    output logic [DSP_NO*WIDTH-1:0]                        ofm
);

    localparam int TAPS  = taps_f(KERNEL_DIM, CHIN);
    localparam int TAP_W = cnt_width_f(TAPS);
    localparam int PIX_W = cnt_width_f(OFM_PIXELS);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(OFM_PIXELS - 1);

    state_e                    state_q, state_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic [PIX_W-1:0]          pix_cnt_q, pix_cnt_d;
    logic                      done_q, done_d;
    logic signed [WIDTH-1:0]   ifm_q, ifm_d;
    logic                      s1_valid_q, s1_valid_d;
    logic                      s1_first_q, s1_first_d;
    logic                      s1_last_q, s1_last_d;
    logic                      ofm_valid_q, ofm_valid_d;
    logic                      w_accept;
    logic                      w_tap_last;
    logic                      w_pix_last;

    assign w_accept   = ifm_valid && (state_q == ST_RUN);
    assign w_tap_last = (tap_q == TAP_LAST);
    assign w_pix_last = (pix_cnt_q == PIX_LAST);

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        pix_cnt_d   = pix_cnt_q;
        done_d      = 1'b0;
        ifm_d       = ifm_q;
        s1_valid_d  = w_accept;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        ofm_valid_d = s1_valid_q && s1_last_q;

        if (w_accept) begin
            ifm_d      = ifm;
            s1_first_d = (tap_q == '0);
            s1_last_d  = w_tap_last;
            tap_d      = w_tap_last ? '0 : tap_q + TAP_W'(1);
            if (w_tap_last) begin
                pix_cnt_d = w_pix_last ? '0 : pix_cnt_q + PIX_W'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                // A start coinciding with done belongs to the run just finished.
                if (start && !done_q) begin
                    state_d   = ST_RUN;
                    tap_d     = '0;
                    pix_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (w_accept && w_tap_last && w_pix_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stage 1 empty means this ofm_valid is the final pixel's.
                if (ofm_valid_q && !s1_valid_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            pix_cnt_q   <= '0;
            done_q      <= 1'b0;
            ifm_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            ofm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            pix_cnt_q   <= pix_cnt_d;
            done_q      <= done_d;
            ifm_q       <= ifm_d;
            s1_valid_q  <= s1_valid_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            ofm_valid_q <= ofm_valid_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign ifm_ready = (state_q == ST_RUN);
    assign w_addr    = tap_q;
    assign ofm_valid = ofm_valid_q;

    generate
        for (genvar i = 0; i < DSP_NO; i++) begin : g_lane
            conv_mac_lane #(
                .WIDTH   (WIDTH),
                .FRAC    (FRAC),
                .TAPS    (TAPS),
                .RELU_EN (RELU_EN)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .pix_i    (ifm_q),
                .w_i      (w_data[i*WIDTH +: WIDTH]),
                .bias_i   (bias[i*WIDTH +: WIDTH]),
                .mac_en_i (s1_valid_q),
                .first_i  (s1_first_q),
                .last_i   (s1_last_q),
                .ofm_o    (ofm[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_conv_expand_engine.sv
// ============================================================================
//  tb_conv_expand_engine
//  Directed bench: ReLU and linear engines driven in lockstep, hand-computed results.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_expand_engine;

    localparam int DSP_NO     = 4;
    localparam int WIDTH      = 16;
    localparam int FRAC       = 8;
    localparam int CHIN       = 2;
    localparam int KERNEL_DIM = 1;
    localparam int OFM_PIXELS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ifm_valid = 1'b0;
    logic [15:0] ifm = '0;
    logic [63:0] bias_v = '0;
    logic [63:0] w_data_r = '0;
    logic [63:0] w_data_l = '0;
    logic [63:0] w_tab [2];

    logic        busy_r, done_r, ifm_ready_r, ofm_valid_r;
    logic        busy_l, done_l, ifm_ready_l, ofm_valid_l;
    logic [0:0]  w_addr_r, w_addr_l;
    logic [63:0] ofm_r, ofm_l;

    conv_expand_engine #(
        .DSP_NO(DSP_NO), .WIDTH(WIDTH), .FRAC(FRAC), .CHIN(CHIN),
        .KERNEL_DIM(KERNEL_DIM), .OFM_PIXELS(OFM_PIXELS), .RELU_EN(1)
    ) u_dut_relu (
        .clk(clk), .rst(rst), .start(start), .busy(busy_r), .done(done_r),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready_r), .ifm(ifm),
        .w_addr(w_addr_r), .w_data(w_data_r), .bias(bias_v),
        .ofm_valid(ofm_valid_r), .ofm(ofm_r)
    );

    conv_expand_engine #(
        .DSP_NO(DSP_NO), .WIDTH(WIDTH), .FRAC(FRAC), .CHIN(CHIN),
        .KERNEL_DIM(KERNEL_DIM), .OFM_PIXELS(OFM_PIXELS), .RELU_EN(0)
    ) u_dut_lin (
        .clk(clk), .rst(rst), .start(start), .busy(busy_l), .done(done_l),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready_l), .ifm(ifm),
        .w_addr(w_addr_l), .w_data(w_data_l), .bias(bias_v),
        .ofm_valid(ofm_valid_l), .ofm(ofm_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data_r <= w_tab[w_addr_r];
        w_data_l <= w_tab[w_addr_l];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    int          ov_n = 0, ovl_n = 0, done_n = 0, done_cyc = -1;
    int          ov_cyc [8];
    logic [63:0] ov_r [8];
    logic [63:0] ov_l [8];
    logic [15:0] pix [6];
    logic [63:0] exp_r [3];
    logic [63:0] exp_l [3];

    always @(negedge clk) begin
        if (ofm_valid_r) begin
            if (ov_n < 8) begin
                ov_cyc[ov_n] = cyc;
                ov_r[ov_n]   = ofm_r;
            end
            ov_n++;
        end
        if (ofm_valid_l) begin
            if (ovl_n < 8) ov_l[ovl_n] = ofm_l;
            ovl_n++;
        end
        if (done_r) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_basic();
        w_tab[0] = {4{16'h0100}};
        w_tab[1] = {4{16'h0100}};
        bias_v   = '0;
        pix = '{16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'hFF00, 16'h0080};
        exp_r = '{{4{16'h0500}}, {4{16'h0200}}, {4{16'h0000}}};
        exp_l = '{{4{16'h0500}}, {4{16'h0200}}, {4{16'hFF80}}};
    endtask

    task automatic set_bias_relu();
        w_tab[0] = {16'h0100, 16'h0100, 16'h0100, 16'hFF00};
        w_tab[1] = {16'h0100, 16'h0100, 16'h0100, 16'hFF00};
        bias_v   = {4{16'h0100}};
        pix = '{16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'hFF00, 16'h0080};
        exp_r = '{{16'h0600, 16'h0600, 16'h0600, 16'h0000},
                  {16'h0300, 16'h0300, 16'h0300, 16'h0000},
                  {16'h0080, 16'h0080, 16'h0080, 16'h0180}};
        exp_l = '{{16'h0600, 16'h0600, 16'h0600, 16'hFC00},
                  {16'h0300, 16'h0300, 16'h0300, 16'hFF00},
                  {16'h0080, 16'h0080, 16'h0080, 16'h0180}};
    endtask

    task automatic set_sat();
        w_tab[0] = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        w_tab[1] = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        bias_v   = '0;
        pix = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h0100, 16'h0000};
        exp_r = '{{16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF},
                  {16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000},
                  {16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF}};
        exp_l = '{{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF},
                  {16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000},
                  {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}};
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_busy"},  busy_r,      0);
        chk({nm, "_done"},  done_r,      0);
        chk({nm, "_rdy"},   ifm_ready_r, 0);
        chk({nm, "_ov"},    ofm_valid_r, 0);
        chk({nm, "_ofm_r"}, ofm_r,       0);
        chk({nm, "_ofm_l"}, ofm_l,       0);
        chk({nm, "_addr"},  w_addr_r,    0);
    endtask

    task automatic run_scn(input string nm, input int stall_tap, input int stall_len,
                           input bit poke_start);
        int last_acc [3];
        bit seen;
        ov_n = 0; ovl_n = 0; done_n = 0; done_cyc = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ifm = pix[k];
            ifm_valid = 1'b1;
            if (poke_start && k == 2) start = 1'b1;
            @(negedge clk);
            chk($sformatf("%s_rdy%0d", nm, k), ifm_ready_r, 1);
            chk($sformatf("%s_addr%0d", nm, k), w_addr_r, k % 2);
            if (k % 2 == 1) last_acc[k / 2] = cyc;
            @(posedge clk); #1;
            start = 1'b0;
            ifm_valid = 1'b0;
            if (k == stall_tap) begin
                ifm = 16'hDEAD;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    if (s == 0 || s == stall_len - 1)
                        chk($sformatf("%s_hold%0d", nm, s), w_addr_r, (k + 1) % 2);
                    @(posedge clk); #1;
                end
            end
        end
        seen = 1'b0;
        for (int g = 0; g < 12 && !seen; g++) begin
            @(negedge clk);
            if (done_r) begin
                seen = 1'b1;
                chk({nm, "_busy_at_done"}, busy_r, 0);
                start = 1'b1;
            end
        end
        chk({nm, "_done_seen"}, seen, 1);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk({nm, "_busy_after"}, busy_r, 0);
        chk({nm, "_rdy_after"}, ifm_ready_r, 0);
        repeat (3) @(negedge clk);
        chk({nm, "_busy_idle"}, busy_r, 0);
        chk({nm, "_ov_count"}, ov_n, 3);
        chk({nm, "_ov_count_lin"}, ovl_n, 3);
        chk({nm, "_done_count"}, done_n, 1);
        chk({nm, "_done_cyc"}, done_cyc, ov_cyc[2] + 1);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("%s_lat%0d", nm, p), ov_cyc[p], last_acc[p] + 2);
            chk($sformatf("%s_relu%0d", nm, p), ov_r[p], exp_r[p]);
            chk($sformatf("%s_lin%0d", nm, p), ov_l[p], exp_l[p]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        w_tab[0] = '0;
        w_tab[1] = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        set_basic();      run_scn("basic", -1, 0, 1'b0);
        set_bias_relu();  run_scn("bias",  -1, 0, 1'b0);
        set_sat();        run_scn("sat",   -1, 0, 1'b0);
        set_basic();      run_scn("stall",  0, 5, 1'b0);
        set_basic();      run_scn("busy_start", -1, 0, 1'b1);

        // Abandon a run while pixel 1 is in flight, then start afresh.
        set_bias_relu();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifm = pix[k];
            ifm_valid = 1'b1;
            @(posedge clk); #1;
        end
        ifm_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk); #1 rst = 1'b0;
        set_basic();      run_scn("after_rst", -1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_expand_engine.md
Name: conv_expand_engine

Overview:
- Parametrised successor to the fixed expand-layer MAC engines: one input-feature-map pixel stream is broadcast to DSP_NO parallel MAC lanes, each with its own weight stream.
- Each lane accumulates KERNEL_DIM²·CHIN taps per output pixel, adds bias, applies optional ReLU, then rescales with saturation.
- Differences from the fixed engines: start/busy/done control, valid/ready input flow control, stall-safe weight fetch, bubble-free back-to-back pixels, parametrised fixed-point format and output-pixel count.
- Weight ROM and bias ROM remain external wrappers.

Parameters:
- DSP_NO, 64: number of parallel MAC lanes (output channels).
- WIDTH, 16: signed pixel, weight, bias and output width.
- FRAC, 8: fractional bits of pixel and weight; output keeps FRAC fractional bits.
- CHIN, 64: input channels.
- KERNEL_DIM, 3: kernel side. TAPS = KERNEL_DIM²·CHIN.
- OFM_PIXELS, 256: output pixels per layer run.
- RELU_EN, 1: 1 clamps negative results to 0; 0 passes them signed.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; starts a run when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last ofm_valid.
- ifm_valid  in  1  ifm holds a valid pixel.
- ifm_ready  out  1  block accepts ifm this cycle.
- ifm  in  WIDTH  signed input pixel, in tap order.
- w_addr  out  clog2(TAPS)  weight ROM address (registered).
- w_data  in  DSP_NO·WIDTH  weight ROM data, 1-cycle read latency; lane i = bits [i·WIDTH +: WIDTH].
- bias  in  DSP_NO·WIDTH  per-lane signed bias; static during a run.
- ofm_valid  out  1  one-cycle pulse; ofm holds one output pixel.
- ofm  out  DSP_NO·WIDTH  per-lane result, same packing as w_data.

Behaviour:
- Reset: state IDLE; busy=0, done=0, ifm_ready=0, ofm_valid=0, ofm=0, w_addr=0; all counters and accumulators cleared. Reset mid-run abandons the run; no done is issued.
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on start.
  - RUN→DRAIN when the last tap of pixel OFM_PIXELS-1 is accepted.
  - DRAIN→IDLE when that pixel's ofm_valid is issued; done pulses in the same cycle as the transition into IDLE.
  - start is ignored outside IDLE.
- ifm_ready = 1 only in RUN. Accept = ifm_valid & ifm_ready.
- tap counter (0..TAPS-1) equals w_addr.
  - Increments on accept; wraps to 0 after TAPS-1 and increments the pixel counter.
  - Held when there is no accept, so w_data stays stable across input stalls.
- Pipeline:
  - Accept at cycle t registers the pixel and a tap-is-first/tap-is-last flag.
  - At t+1 each lane forms the product of the registered pixel and w_data (address presented at t). A first-tap product loads the accumulator; any other product adds to it.
  - Last tap accepted at t gives ofm_valid at t+2.
  - The next pixel's first tap may be accepted at t+1: no bubble and no clear cycle.
- Accumulator width: 2·WIDTH + clog2(TAPS), signed; must never overflow.
- Post-processing, per lane:
  - sum = acc + (sign-extended bias << FRAC).
  - If RELU_EN and sum < 0, sum = 0.
  - res = sum >>> FRAC (arithmetic shift).
  - Saturate res to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Write to ofm and hold until the next ofm_valid.
- Output interface has no backpressure; downstream must sink one ofm per ofm_valid.
- Exactly OFM_PIXELS ofm_valid pulses per run.
- start in the done cycle is ignored; a start is accepted from the cycle after done onward.

Decomposition:
- Shared package conv_pkg: TAPS and accumulator-width derivation functions, state enum (IDLE/RUN/DRAIN), saturate function.
- Sub-module conv_mac_lane: multiply, load/accumulate, bias, ReLU, shift, saturate for one lane.
- conv_expand_engine generates DSP_NO conv_mac_lane instances and owns the control logic and counters.

Test Plan:
Bench parameters: DSP_NO=4, WIDTH=16, FRAC=8, CHIN=2, KERNEL_DIM=1 (TAPS=2), OFM_PIXELS=3, behavioural 1-cycle weight ROM.
1. Basic: weights 0x0100 (1.0), bias 0, ifm 0x0200 then 0x0300, streamed continuously → first ofm_valid 2 cycles after the 2nd accept; every lane = 0x0500.
2. Bias and ReLU: lane0 weight 0xFF00 (-1.0), bias 0x0100, ifm 0x0200,0x0300 → lane0 = 0 with RELU_EN=1; lane0 = 0xFC00 with RELU_EN=0.
3. Saturation: weights 0x7FFF, ifm 0x7FFF on both taps → ofm 0x7FFF; weight 0x8000 with RELU_EN=0 → ofm 0x8000.
4. Stalls: ifm_valid low for 5 cycles between taps → w_addr held; results identical to scenario 1; no extra ofm_valid.
5. Full run: 6 back-to-back taps → exactly 3 ofm_valid pulses, no gap between pixels, then done pulse, busy drops, ifm_ready=0; start during busy has no effect.
6. rst asserted mid-pixel 1, then a new start → all outputs return to reset values immediately; the fresh run produces correct results unaffected by the partial accumulation.
